// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// opcode and ALU encodings, and the decoded control bundle.
package cu_pkg;

   localparam int unsigned OP_BITS  = 5;
   localparam int unsigned ALU_BITS = 4;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_MULDIV,
      CLS_BRANCH,
      CLS_STORE,
      CLS_LOAD
   } op_class_e;

   localparam logic [OP_BITS-1:0] OP_ADD  = 5'b00001;
   localparam logic [OP_BITS-1:0] OP_AND  = 5'b00010;
   localparam logic [OP_BITS-1:0] OP_SUB  = 5'b00011;
   localparam logic [OP_BITS-1:0] OP_MUL  = 5'b00100;
   localparam logic [OP_BITS-1:0] OP_CNB  = 5'b00101;
   localparam logic [OP_BITS-1:0] OP_MOD  = 5'b00111;
   localparam logic [OP_BITS-1:0] OP_BEQ  = 5'b01000;
   localparam logic [OP_BITS-1:0] OP_BGT  = 5'b01001;
   localparam logic [OP_BITS-1:0] OP_ADDI = 5'b10000;
   localparam logic [OP_BITS-1:0] OP_SRL  = 5'b10001;
   localparam logic [OP_BITS-1:0] OP_SLL  = 5'b10010;
   localparam logic [OP_BITS-1:0] OP_SB   = 5'b10011;
   localparam logic [OP_BITS-1:0] OP_LB   = 5'b10100;
   localparam logic [OP_BITS-1:0] OP_LW   = 5'b10101;

   localparam logic [ALU_BITS-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALU_BITS-1:0] ALU_SUB = 4'b0001;
   localparam logic [ALU_BITS-1:0] ALU_MUL = 4'b0010;
   localparam logic [ALU_BITS-1:0] ALU_MOD = 4'b0011;
   localparam logic [ALU_BITS-1:0] ALU_AND = 4'b0100;
   localparam logic [ALU_BITS-1:0] ALU_CNB = 4'b0101;
   localparam logic [ALU_BITS-1:0] ALU_SRL = 4'b1000;
   localparam logic [ALU_BITS-1:0] ALU_SLL = 4'b1001;

   typedef struct packed {
      logic                legal;
      logic [ALU_BITS-1:0] alu;
      logic                alu_src;
      op_class_e           cls;
   } ctrl_t;

   localparam ctrl_t C_ILLEGAL = '{legal: 1'b0, alu: '0, alu_src: 1'b0, cls: CLS_ALU};

   function automatic ctrl_t mk_ctrl(input logic [ALU_BITS-1:0] alu,
                                     input logic                alu_src,
                                     input op_class_e           cls);
      ctrl_t c;
      c.legal   = 1'b1;
      c.alu     = alu;
      c.alu_src = alu_src;
      c.cls     = cls;
      return c;
   endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decode: legality, ALU code, immediate select and
// instruction class. Illegal opcodes decode to an all-zero bundle.
module op_decode
   import cu_pkg::*;
#(
   parameter int unsigned OPCODE_W = 5
) (
   input  logic [OPCODE_W-1:0] opcode,
   output ctrl_t               ctrl
);

   logic [OP_BITS-1:0] w_op;
   logic               w_hi_zero;

   assign w_op      = opcode[OP_BITS-1:0];
   assign w_hi_zero = ((opcode >> OP_BITS) == '0);

   always_comb begin
      ctrl = C_ILLEGAL;
      case (w_op)
         OP_ADD:  ctrl = mk_ctrl(ALU_ADD, 1'b0, CLS_ALU);
         OP_AND:  ctrl = mk_ctrl(ALU_AND, 1'b0, CLS_ALU);
         OP_SUB:  ctrl = mk_ctrl(ALU_SUB, 1'b0, CLS_ALU);
         OP_MUL:  ctrl = mk_ctrl(ALU_MUL, 1'b0, CLS_MULDIV);
         OP_CNB:  ctrl = mk_ctrl(ALU_CNB, 1'b0, CLS_ALU);
         OP_MOD:  ctrl = mk_ctrl(ALU_MOD, 1'b0, CLS_MULDIV);
         OP_BEQ:  ctrl = mk_ctrl(ALU_ADD, 1'b0, CLS_BRANCH);
         OP_BGT:  ctrl = mk_ctrl(ALU_ADD, 1'b0, CLS_BRANCH);
         OP_ADDI: ctrl = mk_ctrl(ALU_ADD, 1'b1, CLS_ALU);
         OP_SRL:  ctrl = mk_ctrl(ALU_SRL, 1'b1, CLS_ALU);
         OP_SLL:  ctrl = mk_ctrl(ALU_SLL, 1'b1, CLS_ALU);
         OP_SB:   ctrl = mk_ctrl(ALU_ADD, 1'b1, CLS_STORE);
         OP_LB:   ctrl = mk_ctrl(ALU_ADD, 1'b1, CLS_LOAD);
         OP_LW:   ctrl = mk_ctrl(ALU_ADD, 1'b1, CLS_LOAD);
         default: ctrl = C_ILLEGAL;
      endcase
      // Opcodes wider than the decoded field are legal only with zero upper bits
      if (!w_hi_zero) begin
         ctrl = C_ILLEGAL;
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// multi-cycle EXEC for MUL/MOD and a handshake-stalled MEM phase.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int unsigned OPCODE_W   = 5,
   parameter int unsigned ALUCTRL_W  = 4,
   parameter int unsigned MULDIV_LAT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 RegW,
   output logic                 ALUSrc,
   output logic                 BranchE,
   output logic                 MemW,
   output logic                 MemtoReg,
   output logic                 pc_en,
   output logic                 illegal,
   output logic                 busy
);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [OPCODE_W-1:0] r_opcode;
   logic [OPCODE_W-1:0] w_opcode_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   ctrl_t               w_ctrl;

   op_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_op_decode (
      .opcode (r_opcode),
      .ctrl   (w_ctrl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_FETCH;
         r_opcode <= '0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_opcode <= w_opcode_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   // Next-state, opcode latch and EXEC down-counter
   always_comb begin
      w_state_nxt  = r_state;
      w_opcode_nxt = r_opcode;
      w_cnt_nxt    = r_cnt;
      case (r_state)
         S_FETCH: begin
            if (instr_valid) begin
               w_opcode_nxt = opcode;
               w_state_nxt  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!w_ctrl.legal) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_EXEC;
               w_cnt_nxt   = (w_ctrl.cls == CLS_MULDIV) ? CNT_W'(MULDIV_LAT - 1) : '0;
            end
         end
         S_EXEC: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               case (w_ctrl.cls)
                  CLS_BRANCH:          w_state_nxt = S_FETCH;
                  CLS_STORE, CLS_LOAD: w_state_nxt = S_MEM;
                  default:             w_state_nxt = S_WB;
               endcase
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               w_state_nxt = (w_ctrl.cls == CLS_STORE) ? S_FETCH : S_WB;
            end
         end
         S_WB:    w_state_nxt = S_FETCH;
         default: w_state_nxt = S_FETCH;
      endcase
   end

   // Control outputs decoded from state and the latched opcode
   always_comb begin
      instr_ready = 1'b0;
      busy        = 1'b0;
      ALUControl  = '0;
      ALUSrc      = 1'b0;
      RegW        = 1'b0;
      MemW        = 1'b0;
      BranchE     = 1'b0;
      MemtoReg    = 1'b0;
      mem_req     = 1'b0;
      pc_en       = 1'b0;
      illegal     = 1'b0;
      if (r_state != S_FETCH) begin
         busy       = 1'b1;
         ALUControl = ALUCTRL_W'(w_ctrl.alu);
         ALUSrc     = w_ctrl.alu_src;
      end
      case (r_state)
         S_FETCH: instr_ready = 1'b1;
         S_DECODE: begin
            if (!w_ctrl.legal) begin
               illegal = 1'b1;
               pc_en   = 1'b1;
            end
         end
         S_EXEC: begin
            if (r_cnt == '0 && w_ctrl.cls == CLS_BRANCH) begin
               BranchE = 1'b1;
               pc_en   = 1'b1;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            MemW    = (w_ctrl.cls == CLS_STORE);
            pc_en   = (w_ctrl.cls == CLS_STORE) && mem_ready;
         end
         S_WB: begin
            RegW     = 1'b1;
            pc_en    = 1'b1;
            MemtoReg = (w_ctrl.cls == CLS_LOAD);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed vector table,
// randomized instruction stream against a phase-timing model, reset corners.
module tb_multicycle_control_unit;

   localparam int LAT  = 4;
   localparam int K_ALU = 0;
   localparam int K_MD  = 1;
   localparam int K_BR  = 2;
   localparam int K_ST  = 3;
   localparam int K_LD  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] opcode;
   logic       instr_valid;
   logic       instr_ready;
   logic       mem_ready;
   logic       mem_req;
   logic [3:0] ALUControl;
   logic       RegW, ALUSrc, BranchE, MemW, MemtoReg, pc_en, illegal, busy;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       ir;
      logic       busy;
      logic [3:0] alu;
      logic       src;
      logic       regw;
      logic       memw;
      logic       br;
      logic       m2r;
      logic       mreq;
      logic       pc;
      logic       ill;
   } outs_t;

   typedef struct packed {
      logic [3:0] alu;
      logic       src;
      logic [7:0] len;
      logic [7:0] regw;
      logic [7:0] br;
      logic [7:0] ill;
      logic [7:0] memw;
      logic [7:0] mreq;
   } summ_t;

   typedef struct {
      logic [4:0] op;
      int         w;
      summ_t      exp;
   } vec_t;

   outs_t obs;
   assign obs = {instr_ready, busy, ALUControl, ALUSrc, RegW, MemW, BranchE,
                 MemtoReg, mem_req, pc_en, illegal};

   multicycle_control_unit #(
      .OPCODE_W   (5),
      .ALUCTRL_W  (4),
      .MULDIV_LAT (LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .ALUControl  (ALUControl),
      .RegW        (RegW),
      .ALUSrc      (ALUSrc),
      .BranchE     (BranchE),
      .MemW        (MemW),
      .MemtoReg    (MemtoReg),
      .pc_en       (pc_en),
      .illegal     (illegal),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Instruction-set properties, straight from the opcode table
   function automatic void props(input logic [4:0] op, output logic legal,
                                 output logic [3:0] alu, output logic src, output int kind);
      legal = 1'b1; alu = 4'd0; src = 1'b0; kind = K_ALU;
      case (op)
         5'b00001: ;
         5'b00010: alu = 4'b0100;
         5'b00011: alu = 4'b0001;
         5'b00100: begin alu = 4'b0010; kind = K_MD; end
         5'b00101: alu = 4'b0101;
         5'b00111: begin alu = 4'b0011; kind = K_MD; end
         5'b01000: kind = K_BR;
         5'b01001: kind = K_BR;
         5'b10000: src = 1'b1;
         5'b10001: begin alu = 4'b1000; src = 1'b1; end
         5'b10010: begin alu = 4'b1001; src = 1'b1; end
         5'b10011: begin src = 1'b1; kind = K_ST; end
         5'b10100: begin src = 1'b1; kind = K_LD; end
         5'b10101: begin src = 1'b1; kind = K_LD; end
         default:  legal = 1'b0;
      endcase
   endfunction

   // Last EXEC cycle index, counted from the accepting cycle 0
   function automatic int exec_end(input int kind);
      return (kind == K_MD) ? 1 + LAT : 2;
   endfunction

   // Cycle index at which the unit is back in FETCH
   function automatic int exp_len(input logic [4:0] op, input int w);
      logic legal; logic [3:0] alu; logic src; int kind; int xe;
      props(op, legal, alu, src, kind);
      xe = exec_end(kind);
      if (!legal)        return 2;
      if (kind == K_BR)  return 3;
      if (kind == K_ST)  return xe + 2 + w;
      if (kind == K_LD)  return xe + 3 + w;
      return xe + 2;
   endfunction

   // Expected outputs in cycle k of an instruction with w memory wait cycles
   function automatic outs_t model(input logic [4:0] op, input int w, input int k);
      outs_t e; logic legal; logic [3:0] alu; logic src; int kind; int xe; int len;
      props(op, legal, alu, src, kind);
      xe  = exec_end(kind);
      len = exp_len(op, w);
      e   = '0;
      if (k == 0 || k >= len) begin
         e.ir = 1'b1;
         return e;
      end
      e.busy = 1'b1; e.alu = alu; e.src = src;
      if (k == 1) begin
         e.ill = !legal; e.pc = !legal;
      end else if (k <= xe) begin
         e.br = (kind == K_BR); e.pc = (kind == K_BR);
      end else if ((kind == K_ST || kind == K_LD) && k <= xe + 1 + w) begin
         e.mreq = 1'b1;
         e.memw = (kind == K_ST);
         e.pc   = (kind == K_ST) && (k == xe + 1 + w);
      end else begin
         e.regw = 1'b1; e.pc = 1'b1; e.m2r = (kind == K_LD);
      end
      return e;
   endfunction

   task automatic check_outs(input string name, input int k, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got ir,busy,alu,src,regw,memw,br,m2r,mreq,pc,ill=%b expected %b",
                  name, k, act, exp);
      end
   endtask

   function automatic summ_t mk_summ(input logic [3:0] alu, input logic src, input int len,
                                     input int regw, input int br, input int ill,
                                     input int memw, input int mreq);
      summ_t s;
      s.alu = alu; s.src = src; s.len = 8'(len); s.regw = 8'(regw); s.br = 8'(br);
      s.ill = 8'(ill); s.memw = 8'(memw); s.mreq = 8'(mreq);
      return s;
   endfunction

   // Issue one instruction, check every cycle, and summarise what was seen
   task automatic run_instr(input logic [4:0] op, input int w, output summ_t s);
      logic legal; logic [3:0] alu; logic src; int kind; int xe; int len; string nm;
      props(op, legal, alu, src, kind);
      xe  = exec_end(kind);
      len = exp_len(op, w);
      nm  = $sformatf("op%b_w%0d", op, w);
      s   = '0;
      @(negedge clk);
      opcode = op; instr_valid = 1'b1; mem_ready = 1'($urandom);
      #1;
      check_outs(nm, 0, obs, model(op, w, 0));
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k >= len) begin
            instr_valid = 1'b0;
         end else begin
            instr_valid = 1'($urandom);
            opcode      = 5'($urandom);
         end
         if ((kind == K_ST || kind == K_LD) && k > xe) mem_ready = (k >= xe + 1 + w);
         else                                          mem_ready = 1'($urandom);
         #1;
         check_outs(nm, k, obs, model(op, w, k));
         if (k == 1) begin s.alu = obs.alu; s.src = obs.src; end
         if (obs.regw && s.regw == 0) s.regw = 8'(k);
         if (obs.br   && s.br   == 0) s.br   = 8'(k);
         if (obs.ill  && s.ill  == 0) s.ill  = 8'(k);
         if (obs.memw) s.memw = s.memw + 8'd1;
         if (obs.mreq) s.mreq = s.mreq + 8'd1;
         if (obs.ir) begin
            s.len = 8'(k);
            break;
         end
      end
      instr_valid = 1'b0;
      if (s.len == 0) begin
         checks++; failures++;
         $display("FAIL %s timeout: no return to FETCH within 40 cycles, required by cycle %0d", nm, len);
      end
   endtask

   vec_t       vecs[$];
   logic [4:0] legal_ops [14] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00111,
                                  5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10010, 5'b10011,
                                  5'b10100, 5'b10101};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      summ_t s;
      outs_t idle;
      idle    = '0;
      idle.ir = 1'b1;

      vecs.push_back('{5'b00001, 0, mk_summ(4'b0000, 1'b0, 4, 3, 0, 0, 0, 0)});
      vecs.push_back('{5'b00010, 0, mk_summ(4'b0100, 1'b0, 4, 3, 0, 0, 0, 0)});
      vecs.push_back('{5'b00011, 0, mk_summ(4'b0001, 1'b0, 4, 3, 0, 0, 0, 0)});
      vecs.push_back('{5'b00100, 0, mk_summ(4'b0010, 1'b0, 7, 6, 0, 0, 0, 0)});
      vecs.push_back('{5'b00101, 0, mk_summ(4'b0101, 1'b0, 4, 3, 0, 0, 0, 0)});
      vecs.push_back('{5'b00111, 0, mk_summ(4'b0011, 1'b0, 7, 6, 0, 0, 0, 0)});
      vecs.push_back('{5'b01000, 0, mk_summ(4'b0000, 1'b0, 3, 0, 2, 0, 0, 0)});
      vecs.push_back('{5'b01001, 0, mk_summ(4'b0000, 1'b0, 3, 0, 2, 0, 0, 0)});
      vecs.push_back('{5'b10000, 0, mk_summ(4'b0000, 1'b1, 4, 3, 0, 0, 0, 0)});
      vecs.push_back('{5'b10001, 0, mk_summ(4'b1000, 1'b1, 4, 3, 0, 0, 0, 0)});
      vecs.push_back('{5'b10010, 0, mk_summ(4'b1001, 1'b1, 4, 3, 0, 0, 0, 0)});
      vecs.push_back('{5'b10011, 0, mk_summ(4'b0000, 1'b1, 4, 0, 0, 0, 1, 1)});
      vecs.push_back('{5'b10011, 2, mk_summ(4'b0000, 1'b1, 6, 0, 0, 0, 3, 3)});
      vecs.push_back('{5'b10100, 1, mk_summ(4'b0000, 1'b1, 6, 5, 0, 0, 0, 2)});
      vecs.push_back('{5'b10101, 3, mk_summ(4'b0000, 1'b1, 8, 7, 0, 0, 0, 4)});
      vecs.push_back('{5'b11111, 0, mk_summ(4'b0000, 1'b0, 2, 0, 0, 1, 0, 0)});
      vecs.push_back('{5'b00110, 0, mk_summ(4'b0000, 1'b0, 2, 0, 0, 1, 0, 0)});
      vecs.push_back('{5'b00000, 0, mk_summ(4'b0000, 1'b0, 2, 0, 0, 1, 0, 0)});

      // Reset is asserted at time zero; outputs must settle before any edge
      rst_n = 1'b0; opcode = '0; instr_valid = 1'b0; mem_ready = 1'b0;
      #1;
      check_outs("reset_async", 0, obs, idle);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_instr(vecs[i].op, vecs[i].w, s);
         checks++;
         if (s !== vecs[i].exp) begin
            failures++;
            $display("FAIL table[%0d] op%b: got alu,src,len,regw,br,ill,memw,mreq=%h expected %h",
                     i, vecs[i].op, s, vecs[i].exp);
         end
      end

      // Reset during MUL EXEC cycle 3 must abort with no writeback
      @(negedge clk);
      opcode = 5'b00100; instr_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         instr_valid = 1'b0;
         #1;
         check_outs("mul_pre_reset", k, obs, model(5'b00100, 0, k));
      end
      #1 rst_n = 1'b0;
      #1;
      check_outs("reset_mid_exec", 3, obs, idle);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         check_outs("no_wb_after_reset", k, obs, idle);
      end

      // Reset during a stalled MEM phase, then accept on the first edge after release
      @(negedge clk);
      opcode = 5'b10101; instr_valid = 1'b1; mem_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         instr_valid = 1'b0;
      end
      #1;
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL lw_stall mem_req: got %b expected 1", mem_req);
      end
      rst_n = 1'b0;
      #1;
      check_outs("reset_mid_mem", 0, obs, idle);
      @(negedge clk);
      rst_n = 1'b1; opcode = 5'b00011; instr_valid = 1'b1;
      #1;
      check_outs("first_accept", 0, obs, idle);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         instr_valid = 1'b0;
         #1;
         check_outs("first_accept", k, obs, model(5'b00011, 0, k));
      end

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         logic [4:0] op;
         int         w;
         if ($urandom_range(0, 3) == 0) op = 5'($urandom);
         else                           op = legal_ops[$urandom_range(0, 13)];
         w = int'($urandom_range(0, 4));
         run_instr(op, w, s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
